// File: rtl/rom_loader_pkg.sv
// ---------------------------------------------------------------------------
// rom_loader_pkg
//   Shared definitions for the boot-time ROM-to-RAM copier.
//   - loader_state_t    : copier FSM states (FETCH, WRITE, DONE)
//   - MAX_BYTES_DEFAULT : default copy limit when the ROM never flags done
// ---------------------------------------------------------------------------
package rom_loader_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } loader_state_t;

    localparam logic [31:0] MAX_BYTES_DEFAULT = 32'd65536;

endpackage : rom_loader_pkg

// File: rtl/rom_loader.sv
// ---------------------------------------------------------------------------
// rom_loader
//   Copies the program ROM into main memory after reset, one byte per
//   FETCH/WRITE pair, holding the CPU in reset until the final byte (the one
//   at which the ROM raises rom_done, or the MAX_BYTES-th byte) is accepted.
//
// Parameters
//   BASE_ADDRESS : RAM address that receives ROM byte 0
//   MAX_BYTES    : copy limit used when rom_done never asserts
//
// Ports
//   clk              in   system clock, rising edge
//   reset            in   asynchronous, active-high reset
//   start            in   restart request, honoured only in DONE
//   rom_address      out  ROM address (current index)
//   rom_byte         in   combinational ROM data for rom_address
//   rom_done         in   ROM flag: rom_address is the last image byte
//   ram_address      out  RAM write address
//   ram_data         out  RAM write data
//   ram_write_enable out  RAM write request, held until accepted
//   ram_ready        in   RAM accepts when high together with the request
//   cpu_reset        out  high until the load completes
//   load_complete    out  high in DONE
//   overflow         out  load ended on MAX_BYTES without rom_done
//   byte_count       out  number of bytes written
//   checksum         out  sum of written bytes, modulo 256
// ---------------------------------------------------------------------------
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'd0,
    parameter logic [31:0] MAX_BYTES    = MAX_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] rom_address,
    input  logic [7:0]  rom_byte,
    input  logic        rom_done,
    output logic [31:0] ram_address,
    output logic [7:0]  ram_data,
    output logic        ram_write_enable,
    input  logic        ram_ready,
    output logic        cpu_reset,
    output logic        load_complete,
    output logic        overflow,
    output logic [31:0] byte_count,
    output logic [7:0]  checksum
);

    loader_state_t r_state;
    logic [31:0]   r_index;
    logic          r_last;   // byte being written is the final one
    logic          r_ovf;    // final byte was reached by the limit, not rom_done

    logic          w_at_limit;
    logic          w_accept;

    assign w_at_limit  = (r_index == (MAX_BYTES - 32'd1));
    assign w_accept    = ram_write_enable && ram_ready;
    assign rom_address = r_index;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= ST_FETCH;
            r_index          <= '0;
            r_last           <= 1'b0;
            r_ovf            <= 1'b0;
            ram_address      <= '0;
            ram_data         <= '0;
            ram_write_enable <= 1'b0;
            cpu_reset        <= 1'b1;
            load_complete    <= 1'b0;
            overflow         <= 1'b0;
            byte_count       <= '0;
            checksum         <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    // ROM data is combinational, so it is captured in the
                    // same cycle the index is presented.
                    ram_data         <= rom_byte;
                    ram_address      <= BASE_ADDRESS + r_index;
                    r_last           <= rom_done || w_at_limit;
                    r_ovf            <= !rom_done && w_at_limit;
                    ram_write_enable <= 1'b1;
                    r_state          <= ST_WRITE;
                end

                ST_WRITE: begin
                    if (w_accept) begin
                        byte_count       <= byte_count + 32'd1;
                        checksum         <= checksum + ram_data;
                        ram_write_enable <= 1'b0;
                        if (r_last) begin
                            overflow      <= r_ovf;
                            cpu_reset     <= 1'b0;
                            load_complete <= 1'b1;
                            r_state       <= ST_DONE;
                        end else begin
                            r_index <= r_index + 32'd1;
                            r_state <= ST_FETCH;
                        end
                    end
                end

                ST_DONE: begin
                    if (start) begin
                        r_index       <= '0;
                        byte_count    <= '0;
                        checksum      <= '0;
                        overflow      <= 1'b0;
                        cpu_reset     <= 1'b1;
                        load_complete <= 1'b0;
                        r_state       <= ST_FETCH;
                    end
                end

                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule : rom_loader

// File: tb/tb_rom_loader.sv
// ---------------------------------------------------------------------------
// tb_rom_loader
//   Self-checking bench for rom_loader. A ROM array with a configurable done
//   position drives the DUT; a monitor logs every accepted RAM write and
//   checks request stability while the RAM stalls. Expected results come from
//   a plain model: the copied length, the written address/data sequence, the
//   byte sum and the overflow flag, derived from the ROM contents alone.
// ---------------------------------------------------------------------------
module tb_rom_loader;

    localparam logic [31:0] TB_BASE = 32'hFFFF_FFF8;  // exercises address wrap
    localparam int          TB_MAX  = 20;
    localparam int          TIMEOUT = 500;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] rom_address;
    logic [7:0]  rom_byte;
    logic        rom_done;
    logic [31:0] ram_address;
    logic [7:0]  ram_data;
    logic        ram_write_enable;
    logic        ram_ready;
    logic        cpu_reset;
    logic        load_complete;
    logic        overflow;
    logic [31:0] byte_count;
    logic [7:0]  checksum;

    logic [7:0]  rom_mem [0:31];
    logic        done_en;
    logic [31:0] done_idx;

    wr_t wr_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    rom_loader #(
        .BASE_ADDRESS (TB_BASE),
        .MAX_BYTES    (32'(TB_MAX))
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .rom_address      (rom_address),
        .rom_byte         (rom_byte),
        .rom_done         (rom_done),
        .ram_address      (ram_address),
        .ram_data         (ram_data),
        .ram_write_enable (ram_write_enable),
        .ram_ready        (ram_ready),
        .cpu_reset        (cpu_reset),
        .load_complete    (load_complete),
        .overflow         (overflow),
        .byte_count       (byte_count),
        .checksum         (checksum)
    );

    assign rom_byte = rom_mem[rom_address[4:0]];
    assign rom_done = done_en && (rom_address == done_idx);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Write log and stall-stability monitor, sampled mid-cycle.
    initial begin
        logic        prev_req;
        logic [31:0] prev_addr;
        logic [7:0]  prev_data;
        prev_req = 1'b0;
        prev_addr = '0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (!reset && ram_write_enable) begin
                if (prev_req) begin
                    n_checks++;
                    if (ram_address !== prev_addr || ram_data !== prev_data) begin
                        n_errors++;
                        $display("FAIL stall_stable: got addr %h data %h, required addr %h data %h",
                                 ram_address, ram_data, prev_addr, prev_data);
                    end
                end
                if (ram_ready) wr_q.push_back('{addr: ram_address, data: ram_data});
                prev_req  = !ram_ready;
                prev_addr = ram_address;
                prev_data = ram_data;
            end else begin
                prev_req = 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic fill_rom(input logic en, input int idx);
        for (int i = 0; i < 32; i++) rom_mem[i] = 8'($urandom_range(0, 255));
        done_en  = en;
        done_idx = 32'(idx);
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        start     = 1'b0;
        ram_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        wr_q.delete();
    endtask

    task automatic wait_done(input logic rand_ready, output int cycles);
        cycles = 0;
        while (!load_complete && cycles < TIMEOUT) begin
            @(posedge clk);
            #1;
            cycles++;
            if (rand_ready) ram_ready = 1'($urandom_range(0, 1));
        end
        ram_ready = 1'b1;
        chk("load_finished", {31'd0, load_complete}, 32'd1);
    endtask

    // Reference model: compares the logged writes and final status against
    // the image copy the ROM contents imply.
    task automatic check_result(input string tag);
        int          n;
        logic        exp_ovf;
        logic [7:0]  sum;
        if (done_en && done_idx < 32'(TB_MAX)) begin
            n = int'(done_idx) + 1;
            exp_ovf = 1'b0;
        end else begin
            n = TB_MAX;
            exp_ovf = 1'b1;
        end
        sum = 8'd0;
        for (int i = 0; i < n; i++) sum = sum + rom_mem[i];
        chk({tag, "_nwrites"}, 32'(wr_q.size()), 32'(n));
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            chk({tag, "_wr_addr"}, wr_q[i].addr, TB_BASE + 32'(i));
            chk({tag, "_wr_data"}, {24'd0, wr_q[i].data}, {24'd0, rom_mem[i]});
        end
        chk({tag, "_byte_count"}, byte_count, 32'(n));
        chk({tag, "_checksum"}, {24'd0, checksum}, {24'd0, sum});
        chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
        chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd0);
        chk({tag, "_we_idle"}, {31'd0, ram_write_enable}, 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rom_address"}, rom_address, 32'd0);
        chk({tag, "_ram_address"}, ram_address, 32'd0);
        chk({tag, "_ram_data"}, {24'd0, ram_data}, 32'd0);
        chk({tag, "_we"}, {31'd0, ram_write_enable}, 32'd0);
        chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
        chk({tag, "_load_complete"}, {31'd0, load_complete}, 32'd0);
        chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        chk({tag, "_byte_count"}, byte_count, 32'd0);
        chk({tag, "_checksum"}, {24'd0, checksum}, 32'd0);
    endtask

    task automatic load_stub();
        for (int i = 0; i < 32; i++) rom_mem[i] = 8'd0;
        rom_mem[0] = 8'd1;
        rom_mem[1] = 8'd2;
        rom_mem[2] = 8'd3;
        done_en  = 1'b1;
        done_idx = 32'd2;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        load_stub();
        reset = 1'b1;
        start = 1'b0;
        ram_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
    endtask

    task automatic test_basic();
        load_stub();
        apply_reset();
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                chk("basic_we_after_fetch", {31'd0, ram_write_enable}, 32'd1);
                chk("basic_first_addr", ram_address, TB_BASE);
                chk("basic_first_data", {24'd0, ram_data}, 32'd1);
            end
            if (c == 5) chk("basic_not_done_edge5", {31'd0, load_complete}, 32'd0);
            if (c == 6) chk("basic_done_edge6", {31'd0, load_complete}, 32'd1);
        end
        check_result("basic");
        chk("basic_checksum6", {24'd0, checksum}, 32'd6);
    endtask

    task automatic test_stall();
        load_stub();
        apply_reset();
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            #1;
            ram_ready = !(c >= 3 && c <= 5);
            if (c == 5) begin
                chk("stall_we_held", {31'd0, ram_write_enable}, 32'd1);
                chk("stall_addr", ram_address, TB_BASE + 32'd1);
                chk("stall_data", {24'd0, ram_data}, 32'd2);
            end
            if (c == 6) chk("stall_count_before", byte_count, 32'd1);
            if (c == 7) chk("stall_count_after", byte_count, 32'd2);
            if (c == 8) chk("stall_not_done_edge8", {31'd0, load_complete}, 32'd0);
            if (c == 9) chk("stall_done_edge9", {31'd0, load_complete}, 32'd1);
        end
        check_result("stall");
    endtask

    task automatic test_single_byte();
        int cycles;
        fill_rom(1'b1, 0);
        apply_reset();
        wait_done(1'b0, cycles);
        chk("single_cycles", 32'(cycles), 32'd2);
        check_result("single");
    endtask

    task automatic test_limit();
        int cycles;
        fill_rom(1'b1, TB_MAX - 1);
        apply_reset();
        wait_done(1'b0, cycles);
        chk("limit_cycles", 32'(cycles), 32'(2 * TB_MAX));
        check_result("limit_done");
    endtask

    task automatic test_overflow_and_start();
        int         cycles;
        logic [7:0] first_sum;
        fill_rom(1'b0, 0);
        apply_reset();
        wait_done(1'b1, cycles);
        check_result("ovf");
        first_sum = checksum;
        wr_q.delete();
        // restart from DONE
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("start_load_complete", {31'd0, load_complete}, 32'd0);
        chk("start_overflow_clr", {31'd0, overflow}, 32'd0);
        chk("start_count_clr", byte_count, 32'd0);
        chk("start_sum_clr", {24'd0, checksum}, 32'd0);
        wait_done(1'b1, cycles);
        check_result("restart");
        chk("restart_same_sum", {24'd0, checksum}, {24'd0, first_sum});
    endtask

    task automatic test_start_ignored();
        int cycles;
        fill_rom(1'b1, 7);
        apply_reset();
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;   // in WRITE for byte 1
        @(posedge clk);
        #1;
        start = 1'b1;   // in FETCH for byte 2
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1'b0, cycles);
        check_result("start_ignored");
    endtask

    task automatic test_reset_mid_write();
        int cycles;
        fill_rom(1'b1, 5);
        apply_reset();
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        reset = 1'b0;
        wr_q.delete();
        wait_done(1'b1, cycles);
        check_result("midreset");
    endtask

    task automatic test_random();
        int cycles;
        for (int k = 0; k < 6; k++) begin
            fill_rom(1'b1, $urandom_range(0, TB_MAX - 1));
            apply_reset();
            wait_done(1'b1, cycles);
            check_result("random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_single_byte();
        test_limit();
        test_overflow_and_start();
        test_start_ignored();
        test_reset_mid_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rom_loader
